// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM encoding and default geometry for the cache arbiter.
package cache_pkg;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_LINE_WIDTH = 32;
    localparam int DEF_K = 2;
    localparam int DEF_WR_TIMEOUT = 2 * DEF_K + 2;
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin picker; on a tie the requester not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb grant = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: two-requester round-robin front end issuing one read or write at a time to a cache.
module cache_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int K          = DEF_K,
    parameter int WR_TIMEOUT = 2 * K + 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*LINE_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic                    rsp_hit,
    output logic                    rsp_err,
    output logic [LINE_WIDTH-1:0]   rsp_data,
    output logic [ADDR_WIDTH-1:0]   cache_addr,
    output logic [LINE_WIDTH-1:0]   cache_val,
    output logic                    cache_read,
    output logic                    cache_write,
    input  logic                    cache_hit,
    input  logic [LINE_WIDTH-1:0]   cache_out_val
);
    localparam int CW = $clog2(WR_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WR_TIMEOUT - 1);
    state_t state;
    logic owner, last, op_write, err_q, win, done, in_resp;
    logic [CW-1:0] wr_cnt;
    logic [1:0] grant;
    rr_arbiter2 u_rr (.req(req_valid), .last(last), .grant(grant));
    // cache_hit in the first WRITE cycle still reflects the previous command, so it cannot finish a write
    assign done = (state == WRITE) && (wr_cnt != '0) && cache_hit;
    assign win = grant[1];
    assign in_resp = state == RESP;
    assign req_ready = (reset_n && state == IDLE) ? grant : 2'b00;
    assign cache_read = state == READ;
    assign cache_write = (state == WRITE) && !done;
    assign rsp_valid = in_resp ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_hit = in_resp && (op_write ? !err_q : cache_hit);
    assign rsp_err = in_resp && op_write && err_q;
    assign rsp_data = (in_resp && !op_write && cache_hit) ? cache_out_val : '0;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= 1'b0;
            last <= 1'b1;
            op_write <= 1'b0;
            err_q <= 1'b0;
            wr_cnt <= '0;
            cache_addr <= '0;
            cache_val <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    state <= req_write[win] ? WRITE : READ;
                    owner <= win;
                    last <= win;
                    op_write <= req_write[win];
                    err_q <= 1'b0;
                    wr_cnt <= '0;
                    cache_addr <= win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                    cache_val <= win ? req_wdata[2*LINE_WIDTH-1:LINE_WIDTH] : req_wdata[LINE_WIDTH-1:0];
                end
                READ: state <= RESP;
                WRITE: begin
                    wr_cnt <= wr_cnt + CW'(1);
                    if (done) begin
                        state <= RESP;
                    end else if (wr_cnt == LAST_CNT) begin
                        state <= RESP;
                        err_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed and randomized checks of cache_arbiter against a transaction-level model
// driving a small CLOCK-replacement cache.
module tb_cache_arbiter;
    localparam int AW = 8, LW = 32, KW = 2, TMO = 6;
    logic clock = 0, reset_n = 0;
    logic [1:0] req_valid = 0, req_write = 0;
    logic [2*AW-1:0] req_addr = 0;
    logic [2*LW-1:0] req_wdata = 0;
    logic [1:0] req_ready, rsp_valid;
    logic rsp_hit, rsp_err, cache_read, cache_write, cache_hit;
    logic [LW-1:0] rsp_data, cache_val, cache_out_val;
    logic [AW-1:0] cache_addr;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .K(KW), .WR_TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_hit(rsp_hit), .rsp_err(rsp_err), .rsp_data(rsp_data), .cache_addr(cache_addr),
        .cache_val(cache_val), .cache_read(cache_read), .cache_write(cache_write),
        .cache_hit(cache_hit), .cache_out_val(cache_out_val)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_fail = 0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cache model: KW-way fully associative, CLOCK sweep one step per write cycle, sticky cache_hit
    logic [AW-1:0] m_tag [KW];
    logic [LW-1:0] m_data [KW];
    logic m_vld [KW], m_ref [KW];
    int m_hand = 0, mw;
    logic stuck = 0, flush = 0;

    function automatic int way_of(input logic [AW-1:0] a);
        for (int i = 0; i < KW; i++) if (m_vld[i] === 1'b1 && m_tag[i] == a) return i;
        return -1;
    endfunction
    function automatic int free_way();
        for (int i = 0; i < KW; i++) if (m_vld[i] !== 1'b1) return i;
        return -1;
    endfunction
    function automatic int sweep_len(input logic [AW-1:0] a);
        int n = 0;
        if (way_of(a) >= 0 || free_way() >= 0) return 0;
        while (n < KW && m_ref[(m_hand + n) % KW]) n++;
        return n;
    endfunction

    always @(posedge clock) begin
        if (flush) begin
            for (int i = 0; i < KW; i++) begin
                m_vld[i] <= 1'b0;
                m_ref[i] <= 1'b0;
            end
            m_hand <= 0;
            cache_hit <= 1'b0;
            cache_out_val <= '0;
        end else if (cache_read) begin
            mw = way_of(cache_addr);
            cache_hit <= mw >= 0;
            cache_out_val <= (mw >= 0) ? m_data[mw] : '0;
            if (mw >= 0) m_ref[mw] <= 1'b1;
        end else if (cache_write) begin
            mw = way_of(cache_addr);
            if (mw < 0) mw = free_way();
            if (stuck) begin
                cache_hit <= 1'b0;
            end else if (mw < 0 && m_ref[m_hand]) begin
                m_ref[m_hand] <= 1'b0;
                m_hand <= (m_hand + 1) % KW;
                cache_hit <= 1'b0;
            end else begin
                if (mw < 0) begin
                    mw = m_hand;
                    m_hand <= (m_hand + 1) % KW;
                end
                m_tag[mw] <= cache_addr;
                m_data[mw] <= cache_val;
                m_vld[mw] <= 1'b1;
                m_ref[mw] <= 1'b1;
                cache_hit <= 1'b1;
            end
        end
    end

    // transaction-level reference: one outstanding op with predicted response and latency
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic busy = 0, last_ref = 1, p_owner, p_write, p_hit, p_err;
    logic [AW-1:0] p_addr;
    logic [LW-1:0] p_wdata, p_data;
    int p_t0, p_lat, p_cw_exp, p_cw, p_rd;
    logic [1:0] hs_flag = 0;
    int grants[$];
    int last_lat, last_cw;
    logic last_hit, last_err;
    logic [LW-1:0] last_data;
    logic [LW-1:0] ref_mem [256];

    task automatic monitor();
        int w, s;
        if (!reset_n) begin
            busy = 0;
            last_ref = 1;
            return;
        end
        check("rw_excl", {63'd0, cache_read && cache_write}, 0);
        if (busy) begin
            check("ready_busy", req_ready, 0);
            if (cache_read || cache_write) begin
                check("cache_addr", cache_addr, p_addr);
                if (cache_write) begin
                    check("cache_val", cache_val, p_wdata);
                    p_cw++;
                end else p_rd++;
            end
            if (rsp_valid != 0) begin
                check("rsp_owner", rsp_valid, p_owner ? 2'b10 : 2'b01);
                check("rsp_lat", cyc - p_t0, p_lat);
                check("rsp_hit", rsp_hit, p_hit);
                check("rsp_err", rsp_err, p_err);
                check("rsp_data", rsp_data, p_data);
                check("cmd_in_resp", {cache_read, cache_write}, 0);
                if (p_write) check("wr_cycles", p_cw, p_cw_exp);
                else check("rd_cycles", p_rd, 1);
                last_lat = cyc - p_t0;
                last_cw = p_cw;
                last_hit = rsp_hit;
                last_err = rsp_err;
                last_data = rsp_data;
                busy = 0;
            end else begin
                check("rsp_quiet", {rsp_hit, rsp_err, rsp_data}, 0);
                if (cyc - p_t0 > p_lat) begin
                    check("rsp_timeout", cyc - p_t0, p_lat);
                    busy = 0;
                end
            end
        end else begin
            check("idle_quiet", {rsp_valid, rsp_hit, rsp_err, rsp_data}, 0);
            w = req_valid[!last_ref] ? int'(!last_ref) : (req_valid[last_ref] ? int'(last_ref) : -1);
            check("grant", req_ready, (w < 0) ? 2'b00 : 2'(1 << w));
            if (w >= 0) begin
                p_owner = w[0];
                p_addr = req_addr[w*AW +: AW];
                p_wdata = req_wdata[w*LW +: LW];
                p_write = req_write[w];
                p_t0 = cyc;
                p_cw = 0;
                p_rd = 0;
                p_err = 0;
                p_data = '0;
                if (p_write && stuck) begin
                    p_err = 1;
                    p_hit = 0;
                    p_lat = TMO + 1;
                    p_cw_exp = TMO;
                end else if (p_write) begin
                    s = sweep_len(p_addr);
                    p_hit = 1;
                    p_lat = 3 + s;
                    p_cw_exp = s + 1;
                    ref_mem[p_addr] = p_wdata;
                end else begin
                    p_hit = way_of(p_addr) >= 0;
                    p_data = p_hit ? ref_mem[p_addr] : '0;
                    p_lat = 2;
                end
                grants.push_back(w);
                hs_flag[w] = 1'b1;
                last_ref = w[0];
                busy = 1;
            end
        end
    endtask

    always @(negedge clock) monitor();

    task automatic issue(input int r, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
        req_write[r] = wr;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*LW +: LW] = d;
        req_valid[r] = 1'b1;
        for (int i = 0; i < 20 && !hs_flag[r]; i++) begin
            @(posedge clock);
            #1;
        end
        check("hs_seen", hs_flag[r], 1);
        hs_flag[r] = 1'b0;
        req_valid[r] = 1'b0;
        req_addr[r*AW +: AW] = AW'($urandom);
        req_wdata[r*LW +: LW] = $urandom;
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clock);
            #1;
        end
        check("op_done", busy, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_a"}, {req_ready, rsp_valid, rsp_hit, rsp_err, cache_read, cache_write, cache_addr}, 0);
        check({tag, "_b"}, {rsp_data, cache_val}, 0);
    endtask

    initial begin
        flush = 1;
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        flush = 0;
        reset_n = 1;
        @(posedge clock);
        #1;
        issue(0, 0, 8'h55, 0);
        check("miss_hit", last_hit, 0);
        check("miss_data", last_data, 0);
        check("miss_err", last_err, 0);
        issue(1, 1, 8'h10, 32'hDEADBEEF);
        issue(0, 0, 8'h10, 0);
        check("rdhit_lat", last_lat, 2);
        check("rdhit_hit", last_hit, 1);
        check("rdhit_data", last_data, 32'hDEADBEEF);
        flush = 1;
        @(posedge clock);
        #1;
        flush = 0;
        issue(0, 1, 8'h01, 32'h11111111);
        issue(1, 1, 8'h02, 32'h22222222);
        issue(0, 1, 8'h03, 32'h12345678);
        check("evict_lat", last_lat, 5);
        check("evict_cw", last_cw, 3);
        check("evict_hit", last_hit, 1);
        issue(1, 0, 8'h03, 0);
        check("evict_rd", last_data, 32'h12345678);
        stuck = 1;
        issue(1, 1, 8'h40, 32'h0BADF00D);
        check("tmo_err", last_err, 1);
        check("tmo_hit", last_hit, 0);
        check("tmo_cw", last_cw, TMO);
        check("tmo_lat", last_lat, TMO + 1);
        req_write[1] = 1'b1;
        req_addr[AW +: AW] = 8'h30;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 20 && !hs_flag[1]; i++) begin
            @(posedge clock);
            #1;
        end
        check("rst_hs", hs_flag[1], 1);
        req_valid[1] = 1'b0;
        @(posedge clock);
        #2;
        check("wr_before_rst", cache_write, 1);
        reset_n = 0;
        #1;
        check_outputs_zero("midwr_rst");
        hs_flag = 0;
        stuck = 0;
        @(posedge clock);
        #1;
        reset_n = 1;
        issue(0, 1, 8'h31, 32'hCAFEF00D);
        check("post_rst_hit", last_hit, 1);
        check("post_rst_err", last_err, 0);
        begin
            int g0;
            g0 = grants.size();
            req_write = 2'b00;
            req_valid = 2'b11;
            for (int i = 0; i < 200 && grants.size() < g0 + 6; i++) begin
                @(posedge clock);
                #1;
                for (int r = 0; r < 2; r++) if (hs_flag[r]) begin
                    hs_flag[r] = 1'b0;
                    req_addr[r*AW +: AW] = AW'(8'h20 + $urandom_range(0, 3));
                end
            end
            req_valid = 2'b00;
            check("cont_count", grants.size() - g0, 6);
            for (int k = 0; k < 6 && g0 + k < grants.size(); k++)
                check("cont_grant", grants[g0+k], (k % 2 == 0) ? 1 : 0);
        end
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clock);
            #1;
        end
        hs_flag = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            for (int r = 0; r < 2; r++) begin
                if (hs_flag[r]) begin
                    hs_flag[r] = 1'b0;
                    req_valid[r] = 1'b0;
                end
                if (!req_valid[r]) begin
                    req_addr[r*AW +: AW] = AW'(8'h20 + $urandom_range(0, 4));
                    req_wdata[r*LW +: LW] = $urandom;
                    req_write[r] = 1'($urandom_range(0, 1));
                    req_valid[r] = ($urandom_range(0, 3) == 0);
                end
            end
        end
        req_valid = 2'b00;
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clock);
            #1;
        end
        check("final_idle", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 8, address width; LINE_WIDTH, default 32, data width; K, default 2, cache ways; WR_TIMEOUT, default 2*K+2, maximum write cycles.
REQ-002 clock  in  1  single clock; all state changes on posedge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  out  2  per-requester accept strobe; a transfer occurs when valid&ready.
REQ-006 req_write  in  2  per-requester op: 1 = write, 0 = read.
REQ-007 req_addr  in  2*ADDR_WIDTH  requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 req_wdata  in  2*LINE_WIDTH  requester i at bits [i*LINE_WIDTH +: LINE_WIDTH].
REQ-009 rsp_valid  out  2  one-cycle response pulse to the owning requester.
REQ-010 rsp_hit, rsp_err  out  1 each  response status, shared by both requesters.
REQ-011 rsp_data  out  LINE_WIDTH  read data, shared by both requesters.
REQ-012 cache_addr, cache_val  out  ADDR_WIDTH, LINE_WIDTH  latched address and data driven to the cache.
REQ-013 cache_read, cache_write  out  1 each  cache command strobes.
REQ-014 cache_hit, cache_out_val  in  1, LINE_WIDTH  cache results, valid after the edge that sampled a command.

Function
REQ-015 FSM states SHALL be IDLE, READ, WRITE and RESP.
REQ-016 IDLE: if any req_valid is set, pick a winner, pulse req_ready[winner] combinationally, latch addr, wdata, op and owner, then go to READ or WRITE.
REQ-017 Arbitration SHALL be round-robin: a last-granted pointer (reset 1) is updated on each grant; on a tie the requester not last granted wins.
REQ-018 READ: cache_read = 1 for exactly one cycle, then RESP.
REQ-019 WRITE: wr_cnt is cleared on entry and incremented on each edge spent in WRITE.
- Done when wr_cnt >= 1 and cache_hit = 1; cache_hit is ignored at wr_cnt = 0 because it is stale.
- cache_write = 1 while in WRITE and not done.
- On done, go to RESP with rsp_err = 0.
REQ-020 If wr_cnt reaches WR_TIMEOUT without done, go to RESP with rsp_err = 1 and cache_write deasserted.
REQ-021 RESP: rsp_valid[owner] = 1 for one cycle, then IDLE; no grant is issued in RESP.
REQ-022 Read response: rsp_hit = cache_hit; rsp_data = cache_out_val on a hit, 0 on a miss; rsp_err = 0.
REQ-023 Write response: rsp_hit = !rsp_err; rsp_data = 0.
REQ-024 Outside RESP, rsp_valid, rsp_hit, rsp_err and rsp_data SHALL be 0.
REQ-025 cache_read and cache_write SHALL never be high together, and both SHALL be 0 in IDLE and RESP.
REQ-026 Only one request SHALL be outstanding at a time; req_valid arriving during a busy state waits, ready stays 0.
REQ-027 Latency, counted from the handshake cycle: read response 2 cycles later; write hit response 3 cycles later; write miss response 3 + eviction-sweep cycles later.
REQ-028 req_addr and req_wdata changes after the handshake SHALL NOT affect the operation in flight.

Reset
REQ-029 On reset_n low, the block SHALL asynchronously return to IDLE.
- All outputs go to 0.
- wr_cnt, owner and latched operands are cleared.
REQ-030 A reset asserted mid-WRITE SHALL drop cache_write immediately.
- The cache's internal write state is not reset.
- The next write SHALL still complete via the done rule in REQ-019.

Structure
REQ-031 A shared package cache_pkg SHALL hold the FSM state enum and the default ADDR_WIDTH, LINE_WIDTH, K and WR_TIMEOUT constants.
REQ-032 The round-robin picker SHALL be the sub-module rr_arbiter2.
- Inputs: req[1:0] and last pointer.
- Outputs: grant one-hot.
- Combinational.

Verification
REQ-033 Read hit: preload addr 0x10 = 0xDEADBEEF, requester 0 reads 0x10 -> rsp_valid[0] 2 cycles after handshake, rsp_hit = 1, rsp_data = 0xDEADBEEF.
REQ-034 Read miss: read 0x55 on an empty cache -> rsp_hit = 0, rsp_data = 0, rsp_err = 0.
REQ-035 Write miss with eviction: both ways full with 0x01 and 0x02, write 0x03 = 0x12345678 -> cache_write held through the CLOCK sweep, rsp_hit = 1, a subsequent read of 0x03 returns 0x12345678.
REQ-036 Contention: both requesters valid every cycle for 6 transactions -> grants alternate 1, 0, 1, 0, 1, 0, and no rsp_valid is ever routed to the wrong owner.
REQ-037 Timeout: a cache model that holds cache_hit = 0 -> rsp_err = 1 after WR_TIMEOUT = 6 write cycles, then cache_write = 0.
REQ-038 Reset mid-write: reset_n low at wr_cnt = 1 -> all outputs 0 asynchronously; a write issued after reset completes with rsp_hit = 1.
